// File: rtl/nes_alu_if.sv
// Operand/result bundle between the instruction decoder and the ALU.
// The decoder drives func, operands and current status; the ALU returns the registered result.
interface nes_alu_if #(
  parameter int WIDTH = 8
);
  logic [7:0]       func;
  logic [WIDTH-1:0] status_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] dout;
  logic             wout;
  logic [WIDTH-1:0] status_out;

  modport master (
    output func, status_in, a, b,
    input  dout, wout, status_out
  );

  modport slave (
    input  func, status_in, a, b,
    output dout, wout, status_out
  );
endinterface

// File: rtl/nes_alu.sv
// 6502/2A03 ALU: one op per clock, result/flags/done registered (1-cycle latency), no backpressure.
// NES_ALU_DECIMAL_EN enables BCD ADC/SBC when D is set; default build is binary-only like the 2A03.
module nes_alu #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  nes_alu_if.slave   bus
);
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADC = 8'h01;
  localparam logic [7:0] OP_SBC = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;
  localparam logic [7:0] OP_ORA = 8'h04;
  localparam logic [7:0] OP_EOR = 8'h05;
  localparam logic [7:0] OP_ASL = 8'h06;
  localparam logic [7:0] OP_LSR = 8'h07;
  localparam logic [7:0] OP_ROL = 8'h08;
  localparam logic [7:0] OP_ROR = 8'h09;
  localparam logic [7:0] OP_INC = 8'h0A;
  localparam logic [7:0] OP_DEC = 8'h0B;
  localparam logic [7:0] OP_CMP = 8'h0C;
  localparam logic [7:0] OP_BIT = 8'h0D;

  localparam int FN = 7;
  localparam int FV = 6;
  localparam int FD = 3;
  localparam int FZ = 1;
  localparam int FC = 0;

  typedef logic [WIDTH-1:0] word_t;

  word_t          dout_q, dout_d;
  word_t          status_out_q, status_out_d;
  logic           wout_q, wout_d;

  word_t          st_base;
  word_t          b_eff;
  word_t          ovf;
  word_t          nz_src;
  logic           nz_en;
  logic           cin;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

`ifdef NES_ALU_DECIMAL_EN
  logic [4:0] lo_n, hi_n;
  logic       lo_c;
`endif

  always_comb begin
    st_base     = bus.status_in;
    st_base[5]  = 1'b1;
    cin         = bus.status_in[FC];
    b_eff       = (bus.func == OP_SBC) ? ~bus.b : bus.b;
    sum         = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    diff        = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    ovf         = ~(bus.a ^ b_eff) & (bus.a ^ sum[WIDTH-1:0]);
    dout_d       = dout_q;
    status_out_d = st_base;
    wout_d       = 1'b1;
    nz_en        = 1'b1;
    nz_src       = '0;
`ifdef NES_ALU_DECIMAL_EN
    lo_n = '0;
    hi_n = '0;
    lo_c = 1'b0;
`endif

    case (bus.func)
      OP_NOP: begin
        status_out_d = status_out_q;
        wout_d       = 1'b0;
        nz_en        = 1'b0;
      end
      OP_ADC, OP_SBC: begin
        dout_d           = sum[WIDTH-1:0];
        nz_src           = sum[WIDTH-1:0];
        status_out_d[FC] = sum[WIDTH];
        status_out_d[FV] = ovf[WIDTH-1];
`ifdef NES_ALU_DECIMAL_EN
        // Flags N/V/Z stay binary; only the result and carry are decimal-adjusted.
        if (bus.status_in[FD]) begin
          if (bus.func == OP_ADC) begin
            lo_n = {1'b0, bus.a[3:0]} + {1'b0, bus.b[3:0]} + {4'b0, cin};
            if (lo_n > 5'd9) lo_n = lo_n + 5'd6;
            lo_c = lo_n[4];
            hi_n = {1'b0, bus.a[7:4]} + {1'b0, bus.b[7:4]} + {4'b0, lo_c};
            if (hi_n > 5'd9) hi_n = hi_n + 5'd6;
            status_out_d[FC] = hi_n[4];
          end else begin
            lo_n = {1'b0, bus.a[3:0]} - {1'b0, bus.b[3:0]} - {4'b0, ~cin};
            lo_c = lo_n[4];
            if (lo_c) lo_n = lo_n - 5'd6;
            hi_n = {1'b0, bus.a[7:4]} - {1'b0, bus.b[7:4]} - {4'b0, lo_c};
            if (hi_n[4]) hi_n = hi_n - 5'd6;
          end
          dout_d = {hi_n[3:0], lo_n[3:0]};
        end
`endif
      end
      OP_AND: begin dout_d = bus.a & bus.b; nz_src = dout_d; end
      OP_ORA: begin dout_d = bus.a | bus.b; nz_src = dout_d; end
      OP_EOR: begin dout_d = bus.a ^ bus.b; nz_src = dout_d; end
      OP_ASL: begin
        dout_d           = {bus.a[WIDTH-2:0], 1'b0};
        status_out_d[FC] = bus.a[WIDTH-1];
        nz_src           = dout_d;
      end
      OP_LSR: begin
        dout_d           = {1'b0, bus.a[WIDTH-1:1]};
        status_out_d[FC] = bus.a[0];
        nz_src           = dout_d;
      end
      OP_ROL: begin
        dout_d           = {bus.a[WIDTH-2:0], cin};
        status_out_d[FC] = bus.a[WIDTH-1];
        nz_src           = dout_d;
      end
      OP_ROR: begin
        dout_d           = {cin, bus.a[WIDTH-1:1]};
        status_out_d[FC] = bus.a[0];
        nz_src           = dout_d;
      end
      OP_INC: begin dout_d = bus.a + 1'b1; nz_src = dout_d; end
      OP_DEC: begin dout_d = bus.a - 1'b1; nz_src = dout_d; end
      OP_CMP: begin
        dout_d           = bus.a;
        nz_src           = diff[WIDTH-1:0];
        status_out_d[FC] = diff[WIDTH];
      end
      OP_BIT: begin
        dout_d           = bus.a;
        nz_src           = bus.a & bus.b;
        status_out_d[FN] = bus.b[FN];
        status_out_d[FV] = bus.b[FV];
      end
      default: begin
        wout_d = 1'b0;
        nz_en  = 1'b0;
      end
    endcase

    if (nz_en) begin
      status_out_d[FZ] = (nz_src == '0);
      if (bus.func != OP_BIT) status_out_d[FN] = nz_src[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout_q       <= '0;
      status_out_q <= word_t'(8'h20);
      wout_q       <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      status_out_q <= status_out_d;
      wout_q       <= wout_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.status_out = status_out_q;
  assign bus.wout       = wout_q;
endmodule

// File: tb/tb_nes_alu.sv
// Directed-vector bench for nes_alu with hand-computed results and flags.
module tb_nes_alu;
  logic clk = 1'b0;
  logic reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  nes_alu_if #(.WIDTH(8)) bus ();

  nes_alu #(.WIDTH(8)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic op(input logic [7:0] f, input logic [7:0] av, input logic [7:0] bv,
                    input logic [7:0] sv);
    bus.func      = f;
    bus.a         = av;
    bus.b         = bv;
    bus.status_in = sv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [7:0] d, input logic [7:0] s,
                      input logic w);
    chk({tag, ".dout"}, bus.dout, d);
    chk({tag, ".stat"}, bus.status_out, s);
    chk({tag, ".wout"}, {7'b0, bus.wout}, {7'b0, w});
  endtask

  initial begin
    reset_n = 1'b0;
    op(8'h00, 8'h00, 8'h00, 8'h00);
    chk3("reset", 8'h00, 8'h20, 1'b0);
    reset_n = 1'b1;

    op(8'h01, 8'h50, 8'h50, 8'h00);
    chk3("adc_50_50", 8'hA0, 8'hE0, 1'b1);
    op(8'h00, 8'h11, 8'h22, 8'h00);
    chk3("nop1", 8'hA0, 8'hE0, 1'b0);
    op(8'h00, 8'h33, 8'h44, 8'hFF);
    chk3("nop2", 8'hA0, 8'hE0, 1'b0);

    op(8'h01, 8'hFF, 8'h01, 8'h00);
    chk3("adc_ff_01", 8'h00, 8'h23, 1'b1);
    op(8'h02, 8'h50, 8'hF0, 8'h01);
    chk3("sbc_50_f0", 8'h60, 8'h20, 1'b1);
    op(8'h0C, 8'h10, 8'h10, 8'hC3);
    chk3("cmp_eq", 8'h10, 8'h63, 1'b1);
    op(8'h0C, 8'h05, 8'h10, 8'h00);
    chk3("cmp_lt", 8'h05, 8'hA0, 1'b1);
    op(8'h09, 8'h01, 8'h00, 8'h01);
    chk3("ror", 8'h80, 8'hA1, 1'b1);
    op(8'h06, 8'h80, 8'h00, 8'h00);
    chk3("asl", 8'h00, 8'h23, 1'b1);
    op(8'h07, 8'h01, 8'h00, 8'h80);
    chk3("lsr", 8'h00, 8'h23, 1'b1);
    op(8'h08, 8'h80, 8'h00, 8'h00);
    chk3("rol", 8'h00, 8'h23, 1'b1);
    op(8'h03, 8'hF0, 8'h3C, 8'h4D);
    chk3("and_pass", 8'h30, 8'h6D, 1'b1);
    op(8'h04, 8'h00, 8'h00, 8'h00);
    chk3("ora_zero", 8'h00, 8'h22, 1'b1);
    op(8'h05, 8'hFF, 8'h0F, 8'h00);
    chk3("eor", 8'hF0, 8'hA0, 1'b1);
    op(8'h0D, 8'h0F, 8'hC0, 8'h00);
    chk3("bit", 8'h0F, 8'hE2, 1'b1);

    op(8'hFE, 8'h99, 8'h99, 8'h5A);
    chk3("undef", 8'h0F, 8'h7A, 1'b0);

    op(8'h0A, 8'hFF, 8'h00, 8'h00);
    chk3("inc_ff", 8'h00, 8'h22, 1'b1);
    op(8'h0A, 8'h7F, 8'h00, 8'h00);
    chk3("inc_held", 8'h80, 8'hA0, 1'b1);
    op(8'h0B, 8'h00, 8'h00, 8'h01);
    chk3("dec_00", 8'hFF, 8'hA1, 1'b1);

    op(8'h01, 8'h19, 8'h28, 8'h08);
`ifdef NES_ALU_DECIMAL_EN
    chk3("adc_dec", 8'h47, 8'h28, 1'b1);
`else
    chk3("adc_dec", 8'h41, 8'h28, 1'b1);
`endif

    op(8'h01, 8'h50, 8'h50, 8'h00);
    chk3("pre_rst", 8'hA0, 8'hE0, 1'b1);
    reset_n = 1'b0;
    op(8'h01, 8'h50, 8'h50, 8'h00);
    chk3("rst_mid", 8'h00, 8'h20, 1'b0);
    reset_n = 1'b1;
    op(8'h00, 8'h00, 8'h00, 8'h00);
    chk3("post_rst", 8'h00, 8'h20, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
